// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - request/result/predictor/statistics bundle for the branch resolve unit
interface branch_resolve_unit_if #(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_d1;
    logic [WIDTH-1:0] in_d2;
    logic [IDX_W-1:0] in_idx;
    logic             in_pred;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_taken;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic             out_mispredict;
    logic             out_illegal;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispred;

    modport slave (
        input  in_valid, in_op, in_d1, in_d2, in_idx, in_pred, pred_idx, out_ready,
        output in_ready, pred_taken, out_valid, out_taken, out_mispredict, out_illegal,
               stat_branches, stat_mispred
    );

    modport master (
        output in_valid, in_op, in_d1, in_d2, in_idx, in_pred, pred_idx, out_ready,
        input  in_ready, pred_taken, out_valid, out_taken, out_mispredict, out_illegal,
               stat_branches, stat_mispred
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - registered branch compare with 2-bit BHT and statistics
module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    branch_resolve_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_taken;
    logic             r_mispred;
    logic             r_illegal;
    logic             r_branch;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_stat_br;
    logic [CNT_W-1:0] r_stat_mp;
    logic [1:0]       r_bht [BHT_DEPTH];

    logic             w_in_ready;
    logic             w_accept;
    logic             w_consume;
    logic             w_taken;
    logic             w_illegal;
    logic             w_branch;
    logic             w_mispred;
    logic             w_eq;
    logic             w_d1_neg;
    logic             w_d1_zero;
    logic             w_lt_s;
    logic             w_lt_u;
    logic [1:0]       w_bht_cur;
    logic [1:0]       w_bht_nxt;

    assign w_in_ready = (r_state == S_EMPTY) || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_consume  = (r_state == S_FULL) && bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
            S_FULL:  if (w_consume && !w_accept) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_EMPTY;
        else          r_state <= w_state_nxt;
    end

    assign w_eq      = (bus.in_d1 == bus.in_d2);
    assign w_d1_neg  = bus.in_d1[WIDTH-1];
    assign w_d1_zero = (bus.in_d1 == '0);
    assign w_lt_s    = ($signed(bus.in_d1) < $signed(bus.in_d2));
    assign w_lt_u    = (bus.in_d1 < bus.in_d2);

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        w_branch  = 1'b1;
        case (bus.in_op)
            4'd0: w_branch = 1'b0;
            4'd1: w_taken  = w_eq;
            4'd2: w_taken  = !w_eq;
            4'd3: w_taken  = !w_d1_neg;
            4'd4: w_taken  = !w_d1_neg && !w_d1_zero;
            4'd5: w_taken  = w_d1_neg || w_d1_zero;
            4'd6: w_taken  = w_d1_neg;
            4'd7: w_taken  = w_lt_s;
            4'd8: w_taken  = w_lt_u;
            default: begin
                w_branch  = 1'b0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Non-branch ops never count as mispredicts regardless of the front-end guess.
    assign w_mispred = w_branch && (w_taken != bus.in_pred);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_taken   <= 1'b0;
            r_mispred <= 1'b0;
            r_illegal <= 1'b0;
            r_branch  <= 1'b0;
            r_idx     <= '0;
        end else if (w_accept) begin
            r_taken   <= w_taken;
            r_mispred <= w_mispred;
            r_illegal <= w_illegal;
            r_branch  <= w_branch;
            r_idx     <= bus.in_idx;
        end
    end

    assign w_bht_cur = r_bht[r_idx];
    always_comb begin
        w_bht_nxt = w_bht_cur;
        if (r_taken) begin
            if (w_bht_cur != 2'b11) w_bht_nxt = w_bht_cur + 2'd1;
        end else begin
            if (w_bht_cur != 2'b00) w_bht_nxt = w_bht_cur - 2'd1;
        end
    end

    // Training happens only when the consumer takes the result, so a reset drops it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= 2'b01;
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else if (w_consume && r_branch) begin
            r_bht[r_idx] <= w_bht_nxt;
            r_stat_br    <= r_stat_br + CNT_ONE;
            if (r_mispred) r_stat_mp <= r_stat_mp + CNT_ONE;
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.pred_taken     = r_bht[bus.pred_idx][1];
    assign bus.out_valid      = (r_state == S_FULL);
    assign bus.out_taken      = r_taken;
    assign bus.out_mispredict = r_mispred;
    assign bus.out_illegal    = r_illegal;
    assign bus.stat_branches  = r_stat_br;
    assign bus.stat_mispred   = r_stat_mp;
endmodule
